// File: rtl/cache_refill_controller.sv
// Cache refill controller: fetches missing lines from memory (or forwards them from a
// one-entry write-through buffer) and drains buffered writes to memory when idle.
module cache_refill_controller #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              miss_valid,
    input  logic [ADDR_WIDTH-1:0]             miss_addr,
    output logic                              miss_ready,
    input  logic                              wr_valid,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              wr_ready,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_ack,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              fill_we,
    output logic [INDEX_WIDTH-1:0]            fill_index,
    output logic [ADDR_WIDTH-INDEX_WIDTH-1:0] fill_tag,
    output logic [DATA_WIDTH-1:0]             fill_data,
    output logic                              fill_err,
    output logic                              busy
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FILL  = 2'd3
    } state_e;

    state_e                  state_q,     state_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0]   buf_addr_q,  buf_addr_d;
    logic [DATA_WIDTH-1:0]   buf_data_q,  buf_data_d;
    logic [CNT_WIDTH-1:0]    cnt_q,       cnt_d;
    logic                    mem_req_q,   mem_req_d;
    logic                    mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic                    fill_we_q,   fill_we_d;
    logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
    logic                    fill_err_q,  fill_err_d;
    logic                    forward_s;
    logic                    timeout_s;

    // Forwarding looks only at the buffer as it stood before this edge
    assign forward_s = buf_valid_q && (buf_addr_q == miss_addr);
    assign timeout_s = (cnt_q == CNT_WIDTH'(TIMEOUT - 1));

    // Next-state and datapath decode
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miss_addr_d = miss_addr_q;
        fill_data_d = fill_data_q;
        fill_we_d   = 1'b0;
        fill_err_d  = 1'b0;

        if (wr_valid && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = wr_addr;
            buf_data_d  = wr_data;
        end else begin
            buf_valid_d = buf_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (miss_valid) begin
                    miss_addr_d = miss_addr;
                    if (forward_s) begin
                        fill_data_d = buf_data_q;
                        fill_we_d   = 1'b1;
                        state_d     = ST_FILL;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = miss_addr;
                        cnt_d      = {CNT_WIDTH{1'b0}};
                        state_d    = ST_READ;
                    end
                end else if (buf_valid_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = buf_addr_q;
                    mem_wdata_d = buf_data_q;
                    cnt_d       = {CNT_WIDTH{1'b0}};
                    state_d     = ST_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_ack) begin
                    fill_data_d = mem_rdata;
                    fill_we_d   = 1'b1;
                    mem_req_d   = 1'b0;
                    state_d     = ST_FILL;
                end else if (timeout_s) begin
                    mem_req_d  = 1'b0;
                    fill_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_WRITE: begin
                // A timed-out write is dropped rather than retried
                if (mem_ack) begin
                    buf_valid_d = 1'b0;
                    mem_req_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else if (timeout_s) begin
                    buf_valid_d = 1'b0;
                    mem_req_d   = 1'b0;
                    fill_err_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= {ADDR_WIDTH{1'b0}};
            buf_data_q  <= {DATA_WIDTH{1'b0}};
            cnt_q       <= {CNT_WIDTH{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            miss_addr_q <= {ADDR_WIDTH{1'b0}};
            fill_we_q   <= 1'b0;
            fill_data_q <= {DATA_WIDTH{1'b0}};
            fill_err_q  <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            miss_addr_q <= miss_addr_d;
            fill_we_q   <= fill_we_d;
            fill_data_q <= fill_data_d;
            fill_err_q  <= fill_err_d;
        end
    end

    assign miss_ready = (state_q == ST_IDLE);
    assign wr_ready   = !buf_valid_q;
    assign busy       = (state_q != ST_IDLE) || buf_valid_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fill_we    = fill_we_q;
    assign fill_index = miss_addr_q[INDEX_WIDTH-1:0];
    assign fill_tag   = miss_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign fill_data  = fill_data_q;
    assign fill_err   = fill_err_q;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for cache_refill_controller: a transaction-level model predicts memory
// requests, fills and timeouts; a per-cycle monitor compares the DUT against it.
module tb_cache_refill_controller;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          miss_valid;
    logic [AW-1:0] miss_addr;
    logic          miss_ready;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          fill_we;
    logic [IW-1:0] fill_index;
    logic [AW-IW-1:0] fill_tag;
    logic [DW-1:0] fill_data;
    logic          fill_err;
    logic          busy;

    always #5 clk = ~clk;

    cache_refill_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag),
        .fill_data(fill_data), .fill_err(fill_err), .busy(busy)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            cycles;   // expected mem_req high time, 0 = not checked
    } mem_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } fill_t;

    mem_t  exp_mem[$];
    fill_t exp_fill[$];
    int    exp_err[$];
    logic [AW-1:0] txn_addr[$];

    int mem_rd = 0, fill_rd = 0, err_rd = 0;
    int checks = 0, failures = 0, cyc = 0;
    int ack_delay = 0, ack_cnt = 0;
    bit stray = 1'b0;
    bit wb_valid = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    bit prev_req = 1'b0;
    int req_len = 0, last_req_len = 0;
    mem_t cur;
    logic [48:0] cap = '0;
    int fill_cnt = 0, err_cnt = 0, rd_txn = 0, wr_txn = 0;
    logic [DW-1:0]    last_fill_data = '0;
    logic [IW-1:0]    last_fill_index = '0;
    logic [AW-IW-1:0] last_fill_tag = '0;
    int last_fill_cyc = 0, last_accept_cyc = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'h0001) return 32'h0000_0064;
        return {16'hA5A5, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (mem_req && !prev_req) begin
            req_len = 1;
            txn_addr.push_back(mem_addr);
            if (mem_we) wr_txn++; else rd_txn++;
            if (mem_rd >= exp_mem.size()) begin
                cur.cycles = 0;
                cur.we = 1'b0;
                check("unexpected_mem_req", 64'(mem_req), 64'(0));
            end else begin
                cur = exp_mem[mem_rd];
                mem_rd++;
                check("mem_we", 64'(mem_we), 64'(cur.we));
                check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                if (cur.we) check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end
            cap = {mem_we, mem_addr, mem_wdata};
        end else if (mem_req && prev_req) begin
            req_len++;
            check("mem_hold", 64'({mem_we, mem_addr, mem_wdata}), 64'(cap));
        end else if (!mem_req && prev_req) begin
            last_req_len = req_len;
            if (cur.cycles > 0) check("mem_req_len", 64'(req_len), 64'(cur.cycles));
            if (cur.we) wb_valid = 1'b0;
        end
        prev_req = mem_req;

        if (fill_we) begin
            fill_cnt++;
            last_fill_data  = fill_data;
            last_fill_index = fill_index;
            last_fill_tag   = fill_tag;
            last_fill_cyc   = cyc;
            if (fill_rd >= exp_fill.size()) begin
                check("unexpected_fill", 64'(fill_we), 64'(0));
            end else begin
                check("fill_index", 64'(fill_index), 64'(exp_fill[fill_rd].addr[IW-1:0]));
                check("fill_tag", 64'(fill_tag), 64'(exp_fill[fill_rd].addr[AW-1:IW]));
                check("fill_data", 64'(fill_data), 64'(exp_fill[fill_rd].data));
                check("fill_cycle", 64'(cyc), 64'(exp_fill[fill_rd].cyc));
                fill_rd++;
            end
        end
        if (fill_err) begin
            err_cnt++;
            if (err_rd >= exp_err.size()) begin
                check("unexpected_fill_err", 64'(fill_err), 64'(0));
            end else begin
                check("fill_err_cycle", 64'(cyc), 64'(exp_err[err_rd]));
                err_rd++;
            end
        end
        check("wr_ready", 64'(wr_ready), 64'(!wb_valid));
    endtask

    // Memory responder: acks the ack_delay+1-th cycle of each request
    task automatic respond();
        if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
            stray     = 1'b0;
        end else if (mem_req) begin
            ack_cnt++;
            if (ack_delay >= 0 && ack_cnt == ack_delay + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 32'h0 : mem_word(mem_addr);
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            ack_cnt = 0;
            mem_ack = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
        respond();
    endtask

    task automatic push_miss(input logic [AW-1:0] a, input bit abandon);
        last_accept_cyc = cyc;
        if (wb_valid && wb_addr == a) begin
            exp_fill.push_back('{addr: a, data: wb_data, cyc: cyc + 1});
        end else begin
            exp_mem.push_back('{we: 1'b0, addr: a, wdata: '0,
                                cycles: abandon ? 0 : (ack_delay < 0 ? TO : ack_delay + 1)});
            if (!abandon) begin
                if (ack_delay < 0) exp_err.push_back(cyc + 1 + TO);
                else exp_fill.push_back('{addr: a, data: mem_word(a), cyc: cyc + 2 + ack_delay});
            end
        end
    endtask

    task automatic push_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_mem.push_back('{we: 1'b1, addr: a, wdata: d, cycles: ack_delay + 1});
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic wait_ready(input bit need_miss, input bit need_wr);
        int n = 0;
        while (((need_miss && !miss_ready) || (need_wr && !wr_ready)) && n < 200) begin
            tick();
            n++;
        end
        check("ready_wait", 64'(n < 200), 64'(1));
    endtask

    task automatic issue_miss(input logic [AW-1:0] a, input bit abandon);
        wait_ready(1'b1, 1'b0);
        miss_valid = 1'b1;
        miss_addr  = a;
        push_miss(a, abandon);
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_ready(1'b0, 1'b1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        push_write(a, d);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic issue_both(input logic [AW-1:0] ma, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        wait_ready(1'b1, 1'b1);
        miss_valid = 1'b1;
        miss_addr  = ma;
        wr_valid   = 1'b1;
        wr_addr    = wa;
        wr_data    = wd;
        push_miss(ma, 1'b0);
        push_write(wa, wd);
        tick();
        miss_valid = 1'b0;
        wr_valid   = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while ((busy || mem_req) && n < 300) begin
            tick();
            n++;
        end
        check("settle_idle", 64'(busy), 64'(0));
        tick();
        tick();
        check("mem_txn_count", 64'(mem_rd), 64'(exp_mem.size()));
        check("fill_count", 64'(fill_rd), 64'(exp_fill.size()));
        check("err_count", 64'(err_rd), 64'(exp_err.size()));
    endtask

    initial begin
        int f0, e0, r0, w0, n0;
        reset = 1'b0; miss_valid = 1'b0; miss_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        tick(); tick();
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_fill_we", 64'(fill_we), 64'(0));
        check("rst_fill_err", 64'(fill_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_miss_ready", 64'(miss_ready), 64'(1));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_fill_bus", 64'({fill_index, fill_tag, fill_data}), 64'(0));
        reset = 1'b1;
        tick();

        // Plain miss, three wait cycles
        ack_delay = 3; f0 = fill_cnt;
        issue_miss(16'h0001, 1'b0);
        settle();
        check("r21_fill_pulses", 64'(fill_cnt - f0), 64'(1));
        check("r21_fill_data", 64'(last_fill_data), 64'h64);
        check("r21_fill_index", 64'(last_fill_index), 64'h1);
        check("r21_fill_tag", 64'(last_fill_tag), 64'h0);
        check("r21_latency", 64'(last_fill_cyc - last_accept_cyc), 64'd5);

        // Miss hits the buffered write: forward, then drain
        ack_delay = 2; r0 = rd_txn; w0 = wr_txn; n0 = txn_addr.size();
        issue_write(16'h0003, 32'hDEAD_BEEF);
        issue_miss(16'h0003, 1'b0);
        settle();
        check("r22_fill_data", 64'(last_fill_data), 64'hDEAD_BEEF);
        check("r22_latency", 64'(last_fill_cyc - last_accept_cyc), 64'd1);
        check("r22_reads", 64'(rd_txn - r0), 64'd0);
        check("r22_writes", 64'(wr_txn - w0), 64'd1);
        check("r22_write_addr", 64'(txn_addr[n0]), 64'h3);

        // Simultaneous write and miss: read goes first
        ack_delay = 1; n0 = txn_addr.size();
        issue_both(16'h0004, 16'h0005, 32'h0000_01F4);
        check("r23_wr_ready_low", 64'(wr_ready), 64'(0));
        settle();
        check("r23_first_addr", 64'(txn_addr[n0]), 64'h4);
        check("r23_second_addr", 64'(txn_addr[n0 + 1]), 64'h5);
        check("r23_fill_data", 64'(last_fill_data), 64'({16'hA5A5, 16'h0004}));

        // Read that is never acknowledged
        ack_delay = -1; f0 = fill_cnt; e0 = err_cnt;
        issue_miss(16'h0002, 1'b0);
        settle();
        check("r24_req_len", 64'(last_req_len), 64'd64);
        check("r24_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("r24_no_fill", 64'(fill_cnt - f0), 64'd0);
        check("r24_miss_ready", 64'(miss_ready), 64'(1));

        // Reset in the middle of a read, then a stray ack
        ack_delay = -1; f0 = fill_cnt;
        issue_miss(16'h0007, 1'b1);
        tick(); tick(); tick();
        check("r25_in_read", 64'(mem_req), 64'(1));
        reset = 1'b0;
        wb_valid = 1'b0;
        tick();
        reset = 1'b1;
        check("r25_mem_req", 64'(mem_req), 64'(0));
        check("r25_miss_ready", 64'(miss_ready), 64'(1));
        stray = 1'b1;
        tick(); tick(); tick();
        check("r25_no_fill", 64'(fill_cnt - f0), 64'd0);
        check("r25_idle_req", 64'(mem_req), 64'(0));
        settle();

        // Zero-wait read, then a forward with a nonzero tag
        ack_delay = 0;
        issue_miss(16'h00A5, 1'b0);
        check("t6_tag_a", 64'(fill_tag), 64'h00A);
        issue_write(16'h1234, 32'hCAFE_F00D);
        issue_miss(16'h1234, 1'b0);
        settle();
        check("t6_fill_tag", 64'(last_fill_tag), 64'h123);
        check("t6_fill_index", 64'(last_fill_index), 64'h4);
        check("t6_fill_data", 64'(last_fill_data), 64'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
